// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, loader-written instruction memory and IF/ID register.
// Define IF_FETCH_COUNT_EN to drive o_fetch_count with a saturating count of real fetches.
module instruction_fetch #(
   parameter int                N_BITS      = 32,
   parameter int                ADDR_BITS   = 6,
   parameter logic [N_BITS-1:0] HALT_OPCODE = 32'hFFFFFFFF
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_load_en,
   input  logic [ADDR_BITS-1:0] i_load_addr,
   input  logic [N_BITS-1:0]    i_load_data,
   input  logic                 i_start,
   input  logic                 i_PCWrite,
   input  logic                 i_IF_ID_write,
   input  logic                 i_PCSrc,
   input  logic [N_BITS-1:0]    i_jump_direction,
   input  logic                 i_flush,
   output logic [N_BITS-1:0]    o_instruccion,
   output logic [N_BITS-1:0]    o_pc_4,
   output logic                 o_valid,
   output logic [N_BITS-1:0]    o_pc,
   output logic                 o_halt,
   output logic [1:0]           o_state,
   output logic [31:0]          o_fetch_count
);

   localparam logic [1:0] ST_LOAD   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam int                DEPTH      = 2 ** ADDR_BITS;
   localparam logic [N_BITS-1:0] PC_STEP    = N_BITS'(4);
   localparam logic [N_BITS-1:0] ALIGN_MASK = ~N_BITS'(3);

   logic [N_BITS-1:0] mem [DEPTH];

   logic [1:0]        state;
   logic [N_BITS-1:0] pc_p0;
   logic [N_BITS-1:0] pc_plus4_p0;
   logic [N_BITS-1:0] fetch_word_p0;
   logic [N_BITS-1:0] redirect_pc_p0;
   logic              in_range_p0;
   logic [N_BITS-1:0] instr_p1;
   logic [N_BITS-1:0] pc4_p1;
   logic              vld_p1;
   logic              halt_q;

   // Stage p0: fetch. Byte addresses past the end of memory read as the halt word.
   assign in_range_p0    = (pc_p0[N_BITS-1:ADDR_BITS+2] == '0);
   assign fetch_word_p0  = in_range_p0 ? mem[pc_p0[ADDR_BITS+1:2]] : HALT_OPCODE;
   assign pc_plus4_p0    = pc_p0 + PC_STEP;
   assign redirect_pc_p0 = i_jump_direction & ALIGN_MASK;

   always_ff @(posedge i_clk) begin
      if (!i_reset && (state == ST_LOAD) && i_load_en)
         mem[i_load_addr] <= i_load_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ST_LOAD;
         pc_p0    <= '0;
         instr_p1 <= '0;
         pc4_p1   <= '0;
         vld_p1   <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               pc_p0    <= '0;
               instr_p1 <= '0;
               pc4_p1   <= '0;
               vld_p1   <= 1'b0;
               if (i_start)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (i_PCSrc) begin
                  // A taken redirect overrides a hazard stall on the PC.
                  pc_p0    <= redirect_pc_p0;
                  instr_p1 <= '0;
                  pc4_p1   <= '0;
                  vld_p1   <= 1'b0;
               end else if (i_flush) begin
                  instr_p1 <= '0;
                  pc4_p1   <= '0;
                  vld_p1   <= 1'b0;
                  if (i_PCWrite)
                     pc_p0 <= pc_plus4_p0;
               end else begin
                  if (i_PCWrite)
                     pc_p0 <= pc_plus4_p0;
                  if (i_IF_ID_write) begin
                     instr_p1 <= fetch_word_p0;
                     pc4_p1   <= pc_plus4_p0;
                     vld_p1   <= 1'b1;
                     if (fetch_word_p0 == HALT_OPCODE) begin
                        halt_q <= 1'b1;
                        state  <= ST_HALTED;
                     end
                  end
               end
            end
            ST_HALTED: begin
               instr_p1 <= '0;
               pc4_p1   <= '0;
               vld_p1   <= 1'b0;
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

`ifdef IF_FETCH_COUNT_EN
   logic        fetch_take;
   logic [31:0] fetch_count;

   assign fetch_take = (state == ST_RUN) && !i_PCSrc && !i_flush && i_IF_ID_write;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         fetch_count <= '0;
      else if (fetch_take && (fetch_count != 32'hFFFFFFFF))
         fetch_count <= fetch_count + 32'd1;
   end

   assign o_fetch_count = fetch_count;
`else
   assign o_fetch_count = 32'd0;
`endif

   // Stage p1: IF/ID register outputs.
   assign o_instruccion = instr_p1;
   assign o_pc_4        = pc4_p1;
   assign o_valid       = vld_p1;
   assign o_pc          = pc_p0;
   assign o_halt        = halt_q;
   assign o_state       = state;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline. Holds the PC, the instruction memory (word-addressed, loaded from the debug/loader side) and the IF/ID pipeline register.
- Directly feeds instruccionDecode with o_instruccion and o_pc_4.
- Honours stall requests from the hazard detector, branch/jump redirects, flushes and halt.

Parameters:
- N_BITS, 32, datapath/instruction width.
- ADDR_BITS, 6, instruction memory word-address width; depth = 2**ADDR_BITS words.
- HALT_OPCODE, 32'hFFFFFFFF, instruction encoding that stops fetch.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_load_en  in  1  write i_load_data into instruction memory; honoured only in LOAD state.
- i_load_addr  in  ADDR_BITS  word address for the load.
- i_load_data  in  N_BITS  instruction word to store.
- i_start  in  1  LOAD -> RUN.
- i_PCWrite  in  1  1 = PC may advance; 0 = hold PC (hazard stall).
- i_IF_ID_write  in  1  1 = IF/ID register may update; 0 = hold.
- i_PCSrc  in  1  branch/jump taken; redirect PC.
- i_jump_direction  in  N_BITS  redirect target byte address.
- i_flush  in  1  squash the IF/ID contents.
- o_instruccion  out  N_BITS  IF/ID instruction.
- o_pc_4  out  N_BITS  IF/ID PC+4 of that instruction.
- o_valid  out  1  IF/ID holds a real fetched instruction.
- o_pc  out  N_BITS  current PC.
- o_halt  out  1  halt instruction has been fetched; sticky.
- o_state  out  2  0 = LOAD, 1 = RUN, 2 = HALTED.

Behaviour:
- Reset values:
  - PC = 0, state = LOAD.
  - o_instruccion = 0 (NOP), o_pc_4 = 0, o_valid = 0, o_halt = 0.
  - Memory contents are not cleared.
- LOAD state:
  - i_load_en writes mem[i_load_addr] = i_load_data each cycle it is high.
  - PC held at 0; IF/ID outputs NOP with o_valid = 0.
  - i_start moves to RUN next edge. If i_load_en and i_start are high together, the write completes first.
- RUN state:
  - Fetch index = PC[ADDR_BITS+1:2]. PC is a byte address.
  - PC >= 4*2**ADDR_BITS reads as HALT_OPCODE.
  - Per edge, priority (highest first):
    1. i_reset.
    2. i_PCSrc: PC <= {i_jump_direction[N_BITS-1:2], 2'b00}; IF/ID <= NOP, o_valid = 0. Applies even if i_PCWrite = 0.
    3. i_flush: IF/ID <= NOP, o_valid = 0; PC advances per i_PCWrite.
    4. Normal operation:
       - If i_PCWrite = 1: PC <= PC+4.
       - If i_IF_ID_write = 1: IF/ID <= {mem[index], PC+4}, o_valid = 1.
       - Otherwise the corresponding register holds.
  - Latency: an instruction at PC appears on o_instruccion 1 cycle after PC presents it.
  - Halt detection: when a fetched word equal to HALT_OPCODE is latched into IF/ID:
    - o_halt = 1 and the state becomes HALTED on that same edge.
    - The halt word itself is output with o_valid = 1 so decode can propagate it.
  - PC+4 wraps modulo 2**N_BITS.
- HALTED state:
  - PC frozen.
  - IF/ID loads NOP with o_valid = 0 on the next edge and stays there.
  - i_PCSrc, i_flush, i_start and i_load_en are ignored.
  - Only i_reset leaves HALTED.
- Reset mid-RUN: the next edge restores every reset value and returns to LOAD; memory contents are kept, so i_start re-runs the program.
- i_load_en outside LOAD is ignored; memory is never written in RUN or HALTED.

Optional Feature:
- Macro IF_FETCH_COUNT_EN.
- Defined:
  - Adds output o_fetch_count (32 bit).
  - Counts edges where IF/ID latches a real instruction (o_valid becomes/stays 1 via normal fetch, including the halt word).
  - Reset to 0; saturates at 32'hFFFFFFFF.
- Undefined: the port exists and is tied to 0; no counter logic.

Test Plan:
- Load mem[0..3] = 0x20010005, 0x20020003, 0x00221820, 0xFFFFFFFF; pulse i_start -> o_instruccion shows the four words on consecutive cycles with o_pc_4 = 4, 8, 12, 16; o_halt = 1 with the last word; o_state = 2 thereafter; o_pc frozen at 16.
- Stall: i_PCWrite = 0 and i_IF_ID_write = 0 for 2 cycles while o_instruccion = mem[1] -> o_pc stays 8 and o_instruccion stays 0x20020003 for both cycles; the sequence resumes afterwards.
- Redirect: i_PCSrc = 1 with i_jump_direction = 0x0000000E and i_PCWrite = 0 in the same cycle -> next o_pc = 0x0C, IF/ID = NOP with o_valid = 0; the following cycle o_instruccion = mem[3].
- Flush only: i_flush = 1 at PC = 4 -> IF/ID = NOP with o_valid = 0; o_pc = 8 next cycle.
- Reset mid-run at PC = 8 -> o_state = 0, o_pc = 0, o_valid = 0; i_start again -> mem[0] is refetched unchanged.
- Run off end, ADDR_BITS = 2, no halt word loaded -> at PC = 16 the fetch reads HALT_OPCODE; o_halt = 1.
- With IF_FETCH_COUNT_EN defined, o_fetch_count = 4 after the first scenario.
